// File: rtl/run_length_detector.sv
// Run-length detector: reduces a W-bit vector to a single bit k and counts
// consecutive k=1 cycles. It flags when the run reaches a runtime threshold
// and keeps a hit pulse, a sticky flag and a saturating event counter for
// downstream status/interrupt logic.
module run_length_detector #(
    parameter int W     = 3,
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [W-1:0]     w_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             clr_sticky_i,
    output logic             k_o,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic             z_o,
    output logic             hit_o,
    output logic             sticky_o,
    output logic [EVT_W-1:0] evt_cnt_o
);

    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_XNOR = 2'b01;
    localparam logic [1:0] MODE_AND  = 2'b10;
    localparam logic [1:0] MODE_OR   = 2'b11;

    logic             k;
    logic [CNT_W-1:0] thresh_eff;
    logic             at_cross;
    logic             run_sat;
    logic             evt_sat;

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             hit_q,     hit_d;
    logic             sticky_q,  sticky_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    // Reduce the input vector to one bit according to the selected mode.
    always_comb begin
        k = 1'b0;
        case (mode_i)
            MODE_XOR:  k = ^w_i;
            MODE_XNOR: k = ~^w_i;
            MODE_AND:  k = &w_i;
            MODE_OR:   k = |w_i;
            default:   k = 1'b0;
        endcase
    end

    // A zero threshold would make z permanently high; treat it as 1.
    assign thresh_eff = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

    // A crossing is the edge that takes run_cnt from T-1 to T. Lowering
    // thresh below the current count never passes through T-1, so no hit.
    assign at_cross = (run_cnt_q == (thresh_eff - CNT_W'(1)));
    assign run_sat  = (run_cnt_q == {CNT_W{1'b1}});
    assign evt_sat  = (evt_cnt_q == {EVT_W{1'b1}});

    // Next-state logic for run counter, hit pulse, sticky flag and event counter.
    always_comb begin
        run_cnt_d = run_cnt_q;
        hit_d     = 1'b0;
        sticky_d  = sticky_q;
        evt_cnt_d = evt_cnt_q;

        if (en_i) begin
            if (k) begin
                run_cnt_d = run_sat ? run_cnt_q : run_cnt_q + CNT_W'(1);
            end else begin
                run_cnt_d = '0;
            end

            hit_d = k & at_cross;

            if (hit_q && !evt_sat) begin
                evt_cnt_d = evt_cnt_q + EVT_W'(1);
            end
        end

        // Clear applies even while disabled; a pending hit overrides it.
        if (clr_sticky_i) begin
            sticky_d = 1'b0;
        end
        if (en_i && hit_q) begin
            sticky_d = 1'b1;
        end
    end

    // State registers with synchronous reset that overrides enable.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            run_cnt_q <= '0;
            hit_q     <= 1'b0;
            sticky_q  <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
            hit_q     <= hit_d;
            sticky_q  <= sticky_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign k_o       = k;
    assign run_cnt_o = run_cnt_q;
    assign z_o       = (run_cnt_q >= thresh_eff);
    assign hit_o     = hit_q;
    assign sticky_o  = sticky_q;
    assign evt_cnt_o = evt_cnt_q;

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor of the team's 3-input parity run detector.
- Reduces a W-bit input vector to one bit k using a selectable reduction (XOR/XNOR/AND/OR).
- Counts consecutive cycles with k=1 and flags when the run reaches a runtime-programmable threshold.
- Adds a hit pulse, a sticky flag with clear, and a saturating detection-event counter; sits in front of status/interrupt logic.

Parameters:
- W, 3, input vector width (>=2)
- CNT_W, 4, run-length counter and threshold width
- EVT_W, 8, detection-event counter width

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 = hold all state
- w  in  W  input vector
- mode  in  2  reduction select: 00 XOR, 01 XNOR, 10 AND, 11 OR
- thresh  in  CNT_W  required run length; 0 treated as 1
- clr_sticky  in  1  clears sticky
- k  out  1  combinational reduced bit of w per mode
- run_cnt  out  CNT_W  current consecutive-k count (registered)
- z  out  1  run_cnt >= effective threshold (Moore: depends only on registers and thresh)
- hit  out  1  one-cycle pulse when run first reaches threshold
- sticky  out  1  latched hit indicator
- evt_cnt  out  EVT_W  number of hits, saturating

Behaviour:
- Reset (reset=1 at posedge, regardless of en): run_cnt=0, hit=0, sticky=0, evt_cnt=0. z=0 follows from run_cnt=0 because T>=1.
- Effective threshold: T = (thresh==0) ? 1 : thresh.
- k is purely combinational from w and mode:
  - 00: ^w
  - 01: ~^w
  - 10: &w
  - 11: |w
- Run counter, en=1 at posedge:
  - k=1: run_cnt <= run_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - k=0: run_cnt <= 0.
- en=0: run_cnt, sticky and evt_cnt hold; hit <= 0.
- z = (run_cnt >= T). No added latency: z rises in the cycle after the T-th consecutive k=1 edge. With T=3 this matches the original A->B->C->D behaviour.
- hit register: hit <= en & k & (run_cnt == T-1) & ~reset. hit is therefore high in exactly the cycle z first rises for that run, for one cycle.
- No hit is generated when:
  - run_cnt saturates, or
  - thresh is lowered below the current run_cnt mid-run. z rises immediately in that case, but there is no crossing.
- Raising thresh above run_cnt mid-run: z drops immediately; a later crossing of the new T produces a hit.
- sticky:
  - set when hit is asserted (next edge after hit=1); cleared by clr_sticky.
  - set and clear in the same cycle: set wins.
  - hold when en=0, except clr_sticky still clears.
- evt_cnt increments by 1 at the edge following each hit=1 cycle and saturates at 2^EVT_W-1.
- A k=0 cycle ends the run: run_cnt returns to 0 and z drops the next cycle. A new run needs T further k=1 cycles for the next hit.
- Reset mid-run: all state cleared on that edge; the run restarts from 0.
- Unknown mode is not possible (all 4 codes are defined); no X outputs after reset.

Test Plan:
- W=3, mode=00, thresh=3, w=001 for 3 cycles -> run_cnt 1,2,3; z=1 and hit=1 in the cycle run_cnt=3; evt_cnt=1 and sticky=1 the following cycle.
- Same setup, w=011 (k=0) in cycle 2 of a run -> run_cnt returns to 0, z stays 0, no hit; a restart needs 3 new k cycles.
- mode=10, thresh=0, w=111 for 1 cycle -> z=1 and hit=1 after the first edge (T=1); mode=11 with w=000 -> k=0.
- CNT_W=4, thresh=15, k held 20 cycles -> run_cnt saturates at 15, z stays 1, exactly one hit, evt_cnt=1.
- Run at run_cnt=5 with thresh=8, change thresh to 4 -> z=1 immediately with no hit; then change thresh to 7 -> z=0, and hit fires when run_cnt reaches 7.
- Assert en=0 mid-run -> all counters hold and hit=0. Assert clr_sticky together with a hit -> sticky remains 1. Assert reset at run_cnt=2 -> all outputs 0 on the next cycle.
